// File: rtl/aging_table_server_pkg.sv
// Shared definitions for the connection aging table: default geometry, entry layout and packet-path opcodes.
package aging_table_server_pkg;

  localparam int unsigned W_AGINGTB       = 17;
  localparam int unsigned D_AGINGTB       = 3;
  localparam int unsigned W_TIMESTAMP     = 16;
  localparam int unsigned B_VALID_AGINGTB = 16;
  localparam int unsigned W_CNT           = 16;
  localparam int unsigned RESERVED_IDX    = 0;

  typedef enum logic [1:0] {
    PKT_OP_NOP     = 2'b00,
    PKT_OP_REFRESH = 2'b01,
    PKT_OP_DELETE  = 2'b10,
    PKT_OP_NOP_ALT = 2'b11
  } pkt_op_e;

endpackage

// File: rtl/aging_tb_regfile.sv
// Aging table storage: async-reset register array, one write port, one registered read port.
module aging_tb_regfile #(
  parameter int unsigned W = 17,
  parameter int unsigned D = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [D-1:0] wr_idx,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic [D-1:0] rd_idx,
  output logic [W-1:0] rd_data
);

  localparam int unsigned N = 2 ** D;

  logic [W-1:0] mem [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/aging_table_server.sv
// Aging table server: inspector read/write-back port and packet refresh/delete port sharing one table write port.
module aging_table_server
  import aging_table_server_pkg::*;
#(
  parameter int unsigned w_agingTb       = W_AGINGTB,
  parameter int unsigned d_agingTb       = D_AGINGTB,
  parameter int unsigned w_timestamp     = W_TIMESTAMP,
  parameter int unsigned b_valid_agingTb = B_VALID_AGINGTB,
  parameter int unsigned w_cnt           = W_CNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [d_agingTb-1:0]   idx_agingTb,
  input  logic                   rdValid_agingTb,
  input  logic                   wrValid_agingTb,
  input  logic [w_agingTb-1:0]   data_agingTb,
  output logic [w_agingTb-1:0]   ctx_agingTb,
  input  logic                   pkt_valid,
  input  logic [1:0]             pkt_op,
  input  logic [d_agingTb-1:0]   pkt_idx,
  input  logic [w_timestamp-1:0] cur_timestamp,
  output logic [w_cnt-1:0]       aged_cnt,
  output logic [w_cnt-1:0]       drop_cnt
);

  localparam logic [d_agingTb-1:0] RSV = d_agingTb'(RESERVED_IDX);

  logic                 rd_v0, raw_v, dirty;
  logic [d_agingTb-1:0] rd_idx;
  logic [w_agingTb-1:0] raw;
  logic                 pend_v;
  logic [d_agingTb-1:0] pend_idx;
  logic [w_agingTb-1:0] pend_data;

  logic                 pkt_wr, insp_wr;
  logic [w_agingTb-1:0] pkt_data;
  logic                 w_dirty_hit, w_pkt_hit, w_accept, w_commit, w_defer;
  logic                 pend_cancel, pend_replace, pend_try, pend_dirty_drop, pend_commit;
  logic                 mem_we;
  logic [d_agingTb-1:0] mem_widx;
  logic [w_agingTb-1:0] mem_wdata;
  logic [1:0]           drop_inc;
  logic [w_cnt:0]       aged_sum, drop_sum;

  always_comb begin
    pkt_wr   = pkt_valid && (pkt_op == PKT_OP_REFRESH || pkt_op == PKT_OP_DELETE) && pkt_idx != RSV;
    pkt_data = '0;
    if (pkt_op == PKT_OP_REFRESH) begin
      pkt_data[b_valid_agingTb]   = 1'b1;
      pkt_data[w_timestamp-1:0]   = cur_timestamp;
    end
    insp_wr     = wrValid_agingTb && idx_agingTb != RSV;
    w_dirty_hit = insp_wr && dirty && idx_agingTb == rd_idx;
    w_pkt_hit   = insp_wr && !w_dirty_hit && pkt_wr && idx_agingTb == pkt_idx;
    w_accept    = insp_wr && !w_dirty_hit && !w_pkt_hit;
    w_commit    = w_accept && !pkt_wr;
    w_defer     = w_accept && pkt_wr;
    // An accepted inspector write always supersedes the buffered one, so the
    // buffer only competes for the write port when no new write was accepted.
    pend_cancel     = pend_v && pkt_wr && pend_idx == pkt_idx;
    pend_replace    = pend_v && !pend_cancel && w_accept;
    pend_try        = pend_v && !pend_cancel && !w_accept && !pkt_wr;
    pend_dirty_drop = pend_try && dirty && pend_idx == rd_idx;
    pend_commit     = pend_try && !pend_dirty_drop;

    mem_we    = pkt_wr || w_commit || pend_commit;
    mem_widx  = pkt_wr ? pkt_idx  : (w_commit ? idx_agingTb  : pend_idx);
    mem_wdata = pkt_wr ? pkt_data : (w_commit ? data_agingTb : pend_data);

    drop_inc = {1'b0, w_dirty_hit} + {1'b0, w_pkt_hit} + {1'b0, pend_cancel}
             + {1'b0, pend_replace} + {1'b0, pend_dirty_drop};
    aged_sum = {1'b0, aged_cnt} + (w_cnt + 1)'(w_commit || pend_commit);
    drop_sum = {1'b0, drop_cnt} + (w_cnt + 1)'(drop_inc);
  end

  aging_tb_regfile #(
    .W(w_agingTb),
    .D(d_agingTb)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_idx  (mem_widx),
    .wr_data (mem_wdata),
    .rd_en   (rd_v0),
    .rd_idx  (rd_idx),
    .rd_data (raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v0       <= 1'b0;
      raw_v       <= 1'b0;
      rd_idx      <= '0;
      dirty       <= 1'b0;
      ctx_agingTb <= '0;
      pend_v      <= 1'b0;
      pend_idx    <= '0;
      pend_data   <= '0;
      aged_cnt    <= '0;
      drop_cnt    <= '0;
    end else begin
      rd_v0 <= rdValid_agingTb;
      raw_v <= rd_v0;
      if (raw_v) ctx_agingTb <= raw;
      // rd_idx doubles as the dirty tag for the most recent read.
      if (rdValid_agingTb) begin
        rd_idx <= idx_agingTb;
        dirty  <= 1'b0;
      end else if (pkt_wr && pkt_idx == rd_idx) begin
        dirty <= 1'b1;
      end
      if (w_defer) begin
        pend_v    <= 1'b1;
        pend_idx  <= idx_agingTb;
        pend_data <= data_agingTb;
      end else if (pend_cancel || pend_replace || pend_try) begin
        pend_v <= 1'b0;
      end
      aged_cnt <= aged_sum[w_cnt] ? '1 : aged_sum[w_cnt-1:0];
      drop_cnt <= drop_sum[w_cnt] ? '1 : drop_sum[w_cnt-1:0];
    end
  end

endmodule
